// File: rtl/ddr_ctrl_sim_pkg.sv
// ddr_ctrl_sim_pkg: register offsets, response codes, state enums and byte-strobe merge helper
package ddr_ctrl_sim_pkg;
  localparam logic [7:0] OFF_STATUS    = 8'h00;
  localparam logic [7:0] OFF_CTRL      = 8'h04;
  localparam logic [7:0] OFF_SCRATCH   = 8'h08;
  localparam logic [7:0] OFF_CALIB_CNT = 8'h0C;
  localparam logic [7:0] OFF_ECC_CNT   = 8'h10;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  typedef enum logic [1:0] {IDLE, WR_RESP, RD_RESP} bus_state_e;
  typedef enum logic {CALIB, DONE} calib_state_e;
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/ddr_calib_emu.sv
// ddr_calib_emu: one channel's calibration FSM, saturating cycle counter and registered channel reset
module ddr_calib_emu
  import ddr_ctrl_sim_pkg::*;
#(
  parameter int CALIB_CYCLES = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        recal_i,
  output logic        done_o,
  output logic        ch_rst_o,
  output logic [31:0] cnt_o
);
  localparam logic [20:0] TARGET = 21'(CALIB_CYCLES);
  calib_state_e state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic armed_q, ch_rst_q;
  // counting begins in the cycle after the release edge, so armed_q gates the first post-reset edge
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (recal_i) begin
      state_d = CALIB;
      cnt_d = '0;
    end else if (state_q == CALIB && armed_q) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 21'd1;
      state_d = (cnt_d >= TARGET) ? DONE : CALIB;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CALIB;
      cnt_q <= '0;
      armed_q <= 1'b0;
      ch_rst_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      armed_q <= 1'b1;
      ch_rst_q <= state_q != DONE;
    end
  end
  assign done_o = state_q == DONE;
  assign ch_rst_o = ch_rst_q;
  assign cnt_o = {11'b0, cnt_q};
endmodule

// File: rtl/ddr_ctrl_sim.sv
// ddr_ctrl_sim: AXI-Lite register front end emulating NUM_CH DDR4 controller calibration channels
// Define DDR_CTRL_SIM_ECC_EN to add the ecc_err_pulse input and per-channel ECC_ERR_CNT at 0x10.
module ddr_ctrl_sim
  import ddr_ctrl_sim_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CALIB_CYCLES = 1000,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  ddr4_ui_clk,
  input  logic                  ddr4_ui_clk_sync_rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [NUM_CH-1:0]     init_calib_complete,
  output logic [NUM_CH-1:0]     ch_rst
`ifdef DDR_CTRL_SIM_ECC_EN
  ,
  input  logic [NUM_CH-1:0]     ecc_err_pulse
`endif
);
  bus_state_e state_q, state_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d, rd_word;
  logic [31:0] scratch [NUM_CH];
  logic [31:0] calib_cnt [NUM_CH];
  logic [31:0] ecc_cnt [NUM_CH];
  logic [NUM_CH-1:0] calib_done;
  logic [1:0] wr_ch, rd_ch;
  logic [7:0] wr_off, rd_off;
  logic wr_fire, rd_fire, wr_ok, rd_ok, rst;
  logic unused;
  assign rst = ddr4_ui_clk_sync_rst;
  assign unused = &{1'b0, s_axil_awaddr[ADDR_WIDTH-1:10], s_axil_araddr[ADDR_WIDTH-1:10]};
  assign {wr_ch, wr_off} = s_axil_awaddr[9:0];
  assign {rd_ch, rd_off} = s_axil_araddr[9:0];
  assign wr_ok = int'(wr_ch) < NUM_CH;
  assign rd_ok = int'(rd_ch) < NUM_CH;
  // write beats the read when both are pending in IDLE
  assign wr_fire = state_q == IDLE && s_axil_awvalid && s_axil_wvalid;
  assign rd_fire = state_q == IDLE && !(s_axil_awvalid && s_axil_wvalid) && s_axil_arvalid;
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_ch == 2'(i))
        rd_word = (rd_off == OFF_STATUS)    ? {31'b0, calib_done[i]} :
                  (rd_off == OFF_SCRATCH)   ? scratch[i] :
                  (rd_off == OFF_CALIB_CNT) ? calib_cnt[i] :
                  (rd_off == OFF_ECC_CNT)   ? ecc_cnt[i] : '0;
  end
  always_comb begin
    state_d = state_q;
    bresp_d = bresp_q;
    rresp_d = rresp_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (wr_fire) begin
          state_d = WR_RESP;
          bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (rd_fire) begin
          state_d = RD_RESP;
          rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
          rdata_d = rd_ok ? rd_word : '0;
        end
      end
      WR_RESP: state_d = s_axil_bready ? IDLE : WR_RESP;
      RD_RESP: state_d = s_axil_rready ? IDLE : RD_RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ddr4_ui_clk) begin
    if (rst) begin
      state_q <= IDLE;
      bresp_q <= '0;
      rresp_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      bresp_q <= bresp_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
    end
  end
  assign s_axil_awready = wr_fire && !rst;
  assign s_axil_wready = wr_fire && !rst;
  assign s_axil_arready = rd_fire && !rst;
  assign s_axil_bvalid = state_q == WR_RESP;
  assign s_axil_rvalid = state_q == RD_RESP;
  assign s_axil_bresp = bresp_q;
  assign s_axil_rresp = rresp_q;
  assign s_axil_rdata = rdata_q;
  assign init_calib_complete = calib_done;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr_sel, recal;
    logic [31:0] scratch_q;
    assign wr_sel = wr_fire && wr_ch == 2'(g);
    assign recal = wr_sel && wr_off == OFF_CTRL && s_axil_wdata[0];
    always_ff @(posedge ddr4_ui_clk) begin
      if (rst) scratch_q <= '0;
      else if (wr_sel && wr_off == OFF_SCRATCH) scratch_q <= apply_strb(scratch_q, s_axil_wdata, s_axil_wstrb);
    end
    assign scratch[g] = scratch_q;
    ddr_calib_emu #(.CALIB_CYCLES(CALIB_CYCLES)) u_calib (
      .clk_i   (ddr4_ui_clk),
      .rst_i   (rst),
      .recal_i (recal),
      .done_o  (calib_done[g]),
      .ch_rst_o(ch_rst[g]),
      .cnt_o   (calib_cnt[g])
    );
`ifdef DDR_CTRL_SIM_ECC_EN
    logic [31:0] ecc_q;
    // a clearing write wins over the counter but still records a coincident pulse
    always_ff @(posedge ddr4_ui_clk) begin
      if (rst) ecc_q <= '0;
      else if (wr_sel && wr_off == OFF_ECC_CNT) ecc_q <= {31'b0, ecc_err_pulse[g]};
      else if (ecc_err_pulse[g] && ecc_q != '1) ecc_q <= ecc_q + 32'd1;
    end
    assign ecc_cnt[g] = ecc_q;
`else
    assign ecc_cnt[g] = '0;
`endif
  end
endmodule

// File: tb/tb_ddr_ctrl_sim.sv
// tb_ddr_ctrl_sim: directed-vector bench for ddr_ctrl_sim (4-channel and 2-channel instances share one bus)
module tb_ddr_ctrl_sim;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0] wstrb = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [3:0] icc, chrst;
  logic awready2, wready2, bvalid2, arready2, rvalid2;
  logic [1:0] bresp2, rresp2, icc2, chrst2;
  logic [31:0] rdata2;
  logic [3:0] ecc = '0;
  int n_vec = 0, n_err = 0;
  logic [31:0] d1, d2;
  logic [1:0] r1, r2;
  always #5 clk = ~clk;

  ddr_ctrl_sim #(.NUM_CH(4), .CALIB_CYCLES(16), .ADDR_WIDTH(32)) u_dut (
    .ddr4_ui_clk(clk), .ddr4_ui_clk_sync_rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .init_calib_complete(icc), .ch_rst(chrst)
`ifdef DDR_CTRL_SIM_ECC_EN
    , .ecc_err_pulse(ecc)
`endif
  );

  ddr_ctrl_sim #(.NUM_CH(2), .CALIB_CYCLES(16), .ADDR_WIDTH(32)) u_dut2 (
    .ddr4_ui_clk(clk), .ddr4_ui_clk_sync_rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready2),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready2),
    .s_axil_bresp(bresp2), .s_axil_bvalid(bvalid2), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready2),
    .s_axil_rdata(rdata2), .s_axil_rresp(rresp2), .s_axil_rvalid(rvalid2), .s_axil_rready(rready),
    .init_calib_complete(icc2), .ch_rst(chrst2)
`ifdef DDR_CTRL_SIM_ECC_EN
    , .ecc_err_pulse(2'b00)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves the caller 1ns after the acceptance edge with bready already raised
  task automatic wr_accept(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    for (int n = 0; n < 20 && !awready; n++) tick();
    check("awready", awready, 1);
    check("wready", wready, 1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
  endtask

  task automatic wr_finish(output logic [1:0] resp, output logic [1:0] resp2);
    for (int n = 0; n < 20 && !bvalid; n++) tick();
    check("bvalid", bvalid, 1);
    resp = bresp; resp2 = bresp2;
    tick();
    bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                    output logic [31:0] d2o, output logic [1:0] resp2);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    #1;
    for (int n = 0; n < 20 && !arready; n++) tick();
    check("arready", arready, 1);
    tick();
    arvalid = 1'b0;
    for (int n = 0; n < 20 && !rvalid; n++) tick();
    check("rvalid", rvalid, 1);
    d = rdata; resp = rresp; d2o = rdata2; resp2 = rresp2;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // valids held high under reset must not be accepted
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (3) tick();
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_icc", icc, 4'h0);
    check("rst_chrst", chrst, 4'hF);
    check("rst_chrst2", chrst2, 2'b11);
    rst = 1'b0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 16) check("cal_icc_k16", icc, 4'h0);
      if (k == 17) begin
        check("cal_icc_k17", icc, 4'hF);
        check("cal_chrst_k17", chrst, 4'hF);
        check("cal_icc2_k17", icc2, 2'b11);
      end
      if (k == 18) begin
        check("cal_chrst_k18", chrst, 4'h0);
        check("cal_chrst2_k18", chrst2, 2'b00);
      end
    end
    rd(32'h000, d1, r1, d2, r2);
    check("status0", d1, 1);
    rd(32'h00C, d1, r1, d2, r2);
    check("calib_cnt0", d1, 16);
    // partial-strobe scratch writes
    wr_accept(32'h108, 32'hA5A5_1234, 4'b0011);
    wr_finish(r1, r2);
    check("scr_bresp", r1, 2'b00);
    rd(32'h108, d1, r1, d2, r2);
    check("scr_rdata", d1, 32'h0000_1234);
    check("scr_rresp", r1, 2'b00);
    wr_accept(32'h108, 32'hBEEF_0000, 4'b1100);
    wr_finish(r1, r2);
    rd(32'h108, d1, r1, d2, r2);
    check("scr_upper", d1, 32'hBEEF_1234);
    rd(32'h004, d1, r1, d2, r2);
    check("ctrl_reads0", d1, 0);
    rd(32'h0F0, d1, r1, d2, r2);
    check("undef_rdata", d1, 0);
    check("undef_rresp", r1, 2'b00);
    // recalibrate channel 2
    wr_accept(32'h204, 32'h1, 4'hF);
    check("recal_drop", icc, 4'b1011);
    wr_finish(r1, r2);
    check("recal_chrst", chrst, 4'b0100);
    for (int k = 2; k <= 16; k++) begin
      tick();
      if (k == 15) check("recal_k15", icc, 4'b1011);
      if (k == 16) check("recal_k16", icc, 4'hF);
    end
    rd(32'h20C, d1, r1, d2, r2);
    check("recal_cnt2", d1, 16);
    // recalibrate channel 3 twice; the second restarts the count
    wr_accept(32'h304, 32'h1, 4'hF);
    wr_finish(r1, r2);
    repeat (3) tick();
    wr_accept(32'h304, 32'h1, 4'hF);
    wr_finish(r1, r2);
    for (int k = 2; k <= 16; k++) begin
      tick();
      if (k == 15) check("restart_k15", icc, 4'b0111);
      if (k == 16) check("restart_k16", icc, 4'hF);
    end
    // simultaneous write and read: write first, bvalid/bresp held under backpressure
    awaddr = 32'h008; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; araddr = 32'h008;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    #1;
    check("both_awready", awready, 1);
    check("both_arready", arready, 0);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("hold_bvalid", bvalid, 1);
      check("hold_bresp", bresp, 2'b00);
      check("hold_arready", arready, 0);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("after_b_bvalid", bvalid, 0);
    check("after_b_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    check("wait_rd_rvalid", rvalid, 1);
    check("wait_rd_rdata", rdata, 32'hDEAD_BEEF);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    // back-to-back reads with rready high: one per two cycles
    araddr = 32'h000; arvalid = 1'b1; rready = 1'b1;
    #1;
    check("b2b_ar0", arready, 1);
    tick();
    check("b2b_rv0", rvalid, 1);
    check("b2b_ar1", arready, 0);
    tick();
    check("b2b_ar2", arready, 1);
    check("b2b_rv1", rvalid, 0);
    tick();
    arvalid = 1'b0;
    check("b2b_rv2", rvalid, 1);
    tick();
    rready = 1'b0;
    // channel beyond NUM_CH on the 2-channel instance
    rd(32'h300, d1, r1, d2, r2);
    check("ch3_rdata4", d1, 1);
    check("ch3_rresp4", r1, 2'b00);
    check("ch3_rdata2", d2, 0);
    check("ch3_rresp2", r2, 2'b10);
    wr_accept(32'h308, 32'h55, 4'hF);
    wr_finish(r1, r2);
    check("ch3_bresp4", r1, 2'b00);
    check("ch3_bresp2", r2, 2'b10);
    rd(32'h308, d1, r1, d2, r2);
    check("ch3_scr4", d1, 32'h55);
    check("ch3_scr2", d2, 0);
`ifdef DDR_CTRL_SIM_ECC_EN
    ecc = 4'b0010;
    repeat (3) tick();
    ecc = 4'b0000;
    rd(32'h110, d1, r1, d2, r2);
    check("ecc_cnt3", d1, 3);
    wr_accept(32'h110, 32'h0, 4'hF);
    wr_finish(r1, r2);
    rd(32'h110, d1, r1, d2, r2);
    check("ecc_clear", d1, 0);
`else
    rd(32'h110, d1, r1, d2, r2);
    check("ecc_absent_rdata", d1, 0);
    check("ecc_absent_rresp", r1, 2'b00);
`endif
    // reset in the middle of a read abandons it
    araddr = 32'h000; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    check("abort_rvalid_pre", rvalid, 1);
    rst = 1'b1;
    tick();
    check("abort_rvalid_rst", rvalid, 0);
    check("abort_rdata_rst", rdata, 0);
    check("abort_icc_rst", icc, 4'h0);
    rst = 1'b0;
    rready = 1'b1;
    repeat (3) tick();
    check("abort_rvalid_post", rvalid, 0);
    check("abort_bvalid_post", bvalid, 0);
    rd(32'h108, d1, r1, d2, r2);
    check("abort_scr_cleared", d1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
